// File: rtl/nios2_mul_combine_if.sv
// Handshake and data bundle between the partial-product stage, the combine
// stage and the writeback/result mux.
interface nios2_mul_combine_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_p1;
    logic [31:0] in_p2;
    logic [31:0] in_p3;
    logic        in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    // The combine stage itself.
    modport slave (
        input  in_valid, in_p1, in_p2, in_p3, in_acc, out_ready,
        output in_ready, out_valid, out_result
    );

    // Whatever drives the partial products and consumes the result.
    modport master (
        output in_valid, in_p1, in_p2, in_p3, in_acc, out_ready,
        input  in_ready, out_valid, out_result
    );
endinterface

// File: rtl/nios2_mul_combine.sv
// Combines three 16x16 partial products into the low 32-bit product word,
// with optional multiply-accumulate, as a 2-stage valid/ready pipeline.
module nios2_mul_combine #(
    parameter bit ACC_ENABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    nios2_mul_combine_if.slave     bus
);

    logic        a_valid_q;
    logic [31:0] a_p1_q;
    logic [15:0] a_mid_q;
    logic        a_acc_q;
    logic        b_valid_q;
    logic [31:0] b_result_q;

    logic        b_ready;
    logic        a_ready;
    logic        accept;
    logic        advance;
    logic [15:0] mid_d;
    logic        acc_sel_d;
    logic [31:0] prod_d;
    logic [31:0] res_d;
    logic [31:0] acc_value;

    // Upper halves of p2/p3 only land above bit 31 of the product.
    logic unused_hi;
    assign unused_hi = ^{bus.in_p2[31:16], bus.in_p3[31:16]};

    assign b_ready  = ~b_valid_q | bus.out_ready;
    assign a_ready  = ~a_valid_q | b_ready;
    assign accept   = bus.in_valid & bus.in_ready;
    assign advance  = a_valid_q & b_ready;

    assign bus.in_ready   = a_ready & ~reset;
    assign bus.out_valid  = b_valid_q;
    assign bus.out_result = b_result_q;

    assign mid_d     = bus.in_p2[15:0] + bus.in_p3[15:0];
    assign acc_sel_d = bus.in_acc & ACC_ENABLE;
    assign prod_d    = a_p1_q + {a_mid_q, 16'h0000};
    assign res_d     = a_acc_q ? (acc_value + prod_d) : prod_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_result_q <= 32'h0;
        end else begin
            if (accept) begin
                a_valid_q <= 1'b1;
            end else if (advance) begin
                a_valid_q <= 1'b0;
            end

            if (advance) begin
                b_valid_q  <= 1'b1;
                b_result_q <= res_d;
            end else if (bus.out_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Stage A payload only moves on an accepted transfer, so idle X data never enters.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1_q  <= bus.in_p1;
            a_mid_q <= mid_d;
            a_acc_q <= acc_sel_d;
        end
    end

    generate
        if (ACC_ENABLE) begin : g_acc
            logic [31:0] acc_q;

            // Written on every B load so a plain multiply reseeds the running sum.
            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_q <= 32'h0;
                end else if (advance) begin
                    acc_q <= res_d;
                end
            end

            assign acc_value = acc_q;
        end else begin : g_no_acc
            assign acc_value = 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_nios2_mul_combine.sv
// Directed and random checks of the multiplier combine stage against a
// src1*src2 reference model with accumulator rule.
module tb_nios2_mul_combine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios2_mul_combine_if bus();

    nios2_mul_combine #(.ACC_ENABLE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_acc = 32'h0;
    logic [31:0] pend_s1, pend_s2;
    logic        pend_acc;
    logic        last_fire;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_pending(input logic [31:0] s1, input logic [31:0] s2, input logic acc);
        pend_s1 = s1;
        pend_s2 = s2;
        pend_acc = acc;
        bus.in_p1  = {16'h0, s1[15:0]}  * {16'h0, s2[15:0]};
        bus.in_p2  = {16'h0, s1[15:0]}  * {16'h0, s2[31:16]};
        bus.in_p3  = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
        bus.in_acc = acc;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_p1  = 'x;
        bus.in_p2  = 'x;
        bus.in_p3  = 'x;
        bus.in_acc = 'x;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        logic        fire_in, fire_out;
        logic [63:0] full;
        logic [31:0] e;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        fire_in  = bus.in_valid & bus.in_ready;
        fire_out = bus.out_valid & bus.out_ready;
        if (fire_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'b0, fire_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("txn out result=%h expected=%h", bus.out_result, e);
                check("result", bus.out_result, e);
            end
        end
        if (fire_in) begin
            full = {32'h0, pend_s1} * {32'h0, pend_s2};
            model_acc = pend_acc ? (model_acc + full[31:0]) : full[31:0];
            exp_q.push_back(model_acc);
        end
        last_fire = fire_in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] s1, input logic [31:0] s2, input logic acc);
        drive_pending(s1, s2, acc);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_fire) break;
        end
        check("send_accepted", {31'b0, last_fire}, 32'd1);
        idle_inputs();
    endtask

    task automatic drain();
        idle_inputs();
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int k;
        int n_acc;
        idle_inputs();
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Basic product and latency
        bus.out_ready = 1'b1;
        drive_pending(32'h0001_0002, 32'h0003_0004, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("lat_not_yet", {31'b0, bus.out_valid}, 32'd0);
        tick();
        #1;
        check("lat_valid", {31'b0, bus.out_valid}, 32'd1);
        check("basic_value", bus.out_result, 32'h000A_0008);
        drain();

        // Wrap-around
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Backpressure: only two transactions fit
        bus.out_ready = 1'b0;
        k = 1;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            drive_pending(k, 32'd1, 1'b0);
            bus.in_valid = 1'b1;
            tick();
            if (last_fire) begin
                n_acc++;
                k++;
            end
        end
        idle_inputs();
        check("bp_accepts", n_acc, 32'd2);
        #1;
        check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp_hold0", bus.out_result, 32'd1);
        tick();
        #1;
        check("bp_hold1", bus.out_result, 32'd1);
        bus.out_ready = 1'b1;
        send(32'd3, 32'd1, 1'b0);
        send(32'd4, 32'd1, 1'b0);
        drain();

        // Accumulate chain: 15, 29, 30, 7, then 7+1 shows acc held 7
        send(32'd15, 32'd1, 1'b0);
        send(32'd14, 32'd1, 1'b1);
        send(32'd1,  32'd1, 1'b1);
        send(32'd7,  32'd1, 1'b0);
        send(32'd1,  32'd1, 1'b1);
        drain();

        // Reset with both stages full and acc=0x100
        bus.out_ready = 1'b0;
        send(32'h100, 32'd1, 1'b0);
        send(32'h200, 32'd1, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_out_result", bus.out_result, 32'h0);
        exp_q.delete();
        model_acc = 32'h0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send(32'd5, 32'd1, 1'b1);
        drain();

        // Random streaming with random backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_inputs();
                tick();
            end
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
